// File: rtl/mem_bus_arbiter_if.sv
// Bundle of every master-side and memory-side signal of the shared
// 9-bit-address memory/IO bus.
//   master modport : requester / memory model side (drives commands and
//                    mem_rdata, observes done, rdata and the bus outputs)
//   slave modport  : arbiter side
// Handshake: a master raises mX_cmd (MREAD/MWRITE) with addr/wdata and
// holds all three stable until it sees a one-cycle mX_done; mX_rdata is
// valid in that done cycle. 2'b11 is never a request.
interface mem_bus_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [1:0]        m0_cmd;
  logic [8:0]        m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic [1:0]        m1_cmd;
  logic [8:0]        m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic [1:0]        mem_cmd;
  logic [8:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport master (
    output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, mem_rdata,
    input  m0_done, m0_rdata, m1_done, m1_rdata,
    input  mem_cmd, mem_addr, mem_wdata, busy, owner
  );

  modport slave (
    input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, mem_rdata,
    output m0_done, m0_rdata, m1_done, m1_rdata,
    output mem_cmd, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared memory/IO bus.
// Master 0 is the CPU, master 1 the loader/debug port. One transaction is
// IDLE (grant) -> ISSUE (bus command for one cycle) -> WAIT (WAIT_CYCLES
// cycles, read data captured on the last edge) -> DONE (done pulse).
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   bus         mem_bus_arbiter_if.slave: master commands/results, shared
//               bus outputs, mem_rdata, busy and owner
//   dbg_state_o current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
module mem_bus_arbiter #(
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bus_arbiter_if.slave       bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Counter preload; WAIT lasts WAIT_CYCLES cycles ending on count 0.
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;        // index that wins the next tie
  logic [1:0]        cmd_q, cmd_d;
  logic [8:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              req0, req1;
  logic              grant;

  // 2'b11 is not a request.
  assign req0 = (bus.m0_cmd == MREAD) || (bus.m0_cmd == MWRITE);
  assign req1 = (bus.m1_cmd == MREAD) || (bus.m1_cmd == MWRITE);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Single requester wins outright; a tie goes to the pointer.
          grant   = (req0 && req1) ? rr_q : req1;
          owner_d = grant;
          cmd_d   = grant ? bus.m1_cmd   : bus.m0_cmd;
          addr_d  = grant ? bus.m1_addr  : bus.m0_addr;
          wdata_d = grant ? bus.m1_wdata : bus.m0_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          if (cmd_q == MREAD) begin
            if (owner_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      cmd_q    <= MNONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The command is only non-MNONE in ISSUE so IO decodes fire once;
  // address and data simply show the latched copies.
  assign bus.mem_cmd   = (state_q == S_ISSUE) ? cmd_q : MNONE;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.m0_done   = (state_q == S_DONE) && !owner_q;
  assign bus.m1_done   = (state_q == S_DONE) && owner_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.owner     = owner_q;
  assign dbg_state_o   = state_q;

endmodule
